// File: rtl/vga_pkg.sv
// Shared timing defaults, pattern encoding and pixel type for the VGA test-pattern sequencer.
package vga_pkg;

  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    PAT_BARS = 2'd0,
    PAT_LINE = 2'd1,
    PAT_GRAD = 2'd2,
    PAT_BAD  = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  // The gradient taps hcount[9:2], so the horizontal counter is never narrower than 10 bits.
  function automatic int posWidth(input int total);
    return ($clog2(total) < 10) ? 10 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_pos_counter.sv
// Raster position counters: hcount/vcount, end-of-frame strobe and visible-region flag.
module vga_pos_counter
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int HW       = posWidth(DEF_H_TOTAL),
  parameter int VW       = $clog2(DEF_V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_srst,
  output logic [HW-1:0] o_hcount,
  output logic [VW-1:0] o_vcount,
  output logic          o_wrap,
  output logic          o_visible
);

  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic          w_hLast;
  logic          w_vLast;

  assign w_hLast = (r_hcount == HW'(H_TOTAL - 1));
  assign w_vLast = (r_vcount == VW'(V_TOTAL - 1));

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_hLast) begin
      r_hcount <= '0;
      r_vcount <= w_vLast ? '0 : r_vcount + 1'b1;
    end else begin
      r_hcount <= r_hcount + 1'b1;
    end
  end

  assign o_hcount  = r_hcount;
  assign o_vcount  = r_vcount;
  assign o_wrap    = w_hLast && w_vLast;
  assign o_visible = (r_hcount < HW'(H_ACTIVE)) && (r_vcount < VW'(V_ACTIVE));

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-aligned pattern scheduler: BARS -> LINE -> GRAD, switching only at the frame wrap.
// Define PATTERN_AUTO_CYCLE_EN to also advance every FRAMES_PER_PATTERN frames (gated by i_hold).
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int H_TOTAL            = DEF_H_TOTAL,
  parameter int V_TOTAL            = DEF_V_TOTAL,
  parameter int H_ACTIVE           = DEF_H_ACTIVE,
  parameter int V_ACTIVE           = DEF_V_ACTIVE,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input  logic       i_vga_clk,
  input  logic       i_srst,
  input  logic       i_next_req,
  input  logic       i_hold,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue,
  output logic       o_active,
  output logic       o_frame_start,
  output logic [1:0] o_pattern_id
);

  localparam int HW = posWidth(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] w_hcount;
  logic [VW-1:0] w_vcount;
  logic          w_wrap;
  logic          w_visible;
  logic          w_advance;
  pattern_e      r_state;
  pattern_e      w_stateNext;
  logic          r_pending;
  rgb_t          w_pixel;
  rgb_t          r_pixel;
  logic          r_active;
  logic          r_frameStart;

  vga_pos_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .HW      (HW),
    .VW      (VW)
  ) uPosCounter (
    .i_clk    (i_vga_clk),
    .i_srst   (i_srst),
    .o_hcount (w_hcount),
    .o_vcount (w_vcount),
    .o_wrap   (w_wrap),
    .o_visible(w_visible)
  );

`ifdef PATTERN_AUTO_CYCLE_EN
  localparam int FCW = $clog2(FRAMES_PER_PATTERN + 1);
  logic [FCW-1:0] r_frameCnt;

  // Manual and auto triggers are OR-ed, so a coincident pair still yields one advance.
  assign w_advance = w_wrap && (r_pending || i_next_req ||
                     (!i_hold && (r_frameCnt == FCW'(FRAMES_PER_PATTERN - 1))));

  always_ff @(posedge i_vga_clk) begin
    if (i_srst) begin
      r_frameCnt <= '0;
    end else if (w_advance) begin
      r_frameCnt <= '0;
    end else if (w_wrap && !i_hold) begin
      r_frameCnt <= r_frameCnt + 1'b1;
    end
  end
`else
  logic w_unusedHold;
  assign w_unusedHold = i_hold;
  assign w_advance    = w_wrap && (r_pending || i_next_req);
`endif

  always_ff @(posedge i_vga_clk) begin
    if (i_srst) begin
      r_state   <= PAT_BARS;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_pending <= w_wrap ? 1'b0 : (r_pending || i_next_req);
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      PAT_BARS: if (w_advance) w_stateNext = PAT_LINE;
      PAT_LINE: if (w_advance) w_stateNext = PAT_GRAD;
      PAT_GRAD: if (w_advance) w_stateNext = PAT_BARS;
      default:  w_stateNext = PAT_BARS;
    endcase
  end

  always_comb begin
    w_pixel = '0;
    if (w_visible) begin
      case (r_state)
        PAT_BARS: begin
          if (w_vcount < VW'(V_ACTIVE / 3))          w_pixel = '{8'hFF, 8'h00, 8'h00};
          else if (w_vcount < VW'(2 * V_ACTIVE / 3)) w_pixel = '{8'h00, 8'hFF, 8'h00};
          else                                       w_pixel = '{8'h00, 8'h00, 8'hFF};
        end
        PAT_LINE: begin
          if (w_vcount == VW'(V_ACTIVE / 2)) w_pixel = '{8'hFF, 8'h00, 8'hFF};
          else                               w_pixel = '{8'hFF, 8'hC0, 8'hCB};
        end
        PAT_GRAD: w_pixel = '{w_hcount[9:2], 8'h00, 8'h00};
        default:  w_pixel = '0;
      endcase
    end
  end

  always_ff @(posedge i_vga_clk) begin
    if (i_srst) begin
      r_pixel      <= '0;
      r_active     <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_pixel      <= w_pixel;
      r_active     <= w_visible;
      r_frameStart <= (w_hcount == '0) && (w_vcount == '0);
    end
  end

  assign o_red         = r_pixel.red;
  assign o_green       = r_pixel.green;
  assign o_blue        = r_pixel.blue;
  assign o_active      = r_active;
  assign o_frame_start = r_frameStart;
  assign o_pattern_id  = r_state;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer on a shrunken raster, with a frame-level reference model.
// Honours PATTERN_AUTO_CYCLE_EN the same way as the design build.
module tb_vga_pattern_sequencer;

  localparam int H_TOT = 40;
  localparam int V_TOT = 8;
  localparam int H_ACT = 32;
  localparam int V_ACT = 6;
  localparam int FPP   = 3;
  localparam int FRAME = H_TOT * V_TOT;

  logic       clk;
  logic       srst;
  logic       nextReq;
  logic       holdIn;
  logic [7:0] oRed;
  logic [7:0] oGreen;
  logic [7:0] oBlue;
  logic       oActive;
  logic       oFrameStart;
  logic [1:0] oPatternId;

  int checkCount = 0;
  int passCount  = 0;

  int          mPos;
  int          mPat;
  bit          mPend;
  int          mCnt;
  logic [23:0] expRgb;
  bit          expAct;
  bit          expFs;
  bit          modelValid;
  bit          wrapNow;
  bit          advNow;

  vga_pattern_sequencer #(
    .H_TOTAL           (H_TOT),
    .V_TOTAL           (V_TOT),
    .H_ACTIVE          (H_ACT),
    .V_ACTIVE          (V_ACT),
    .FRAMES_PER_PATTERN(FPP)
  ) dut (
    .i_vga_clk    (clk),
    .i_srst       (srst),
    .i_next_req   (nextReq),
    .i_hold       (holdIn),
    .o_red        (oRed),
    .o_green      (oGreen),
    .o_blue       (oBlue),
    .o_active     (oActive),
    .o_frame_start(oFrameStart),
    .o_pattern_id (oPatternId)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit isVisible(input int pos);
    return ((pos % H_TOT) < H_ACT) && ((pos / H_TOT) < V_ACT);
  endfunction

  function automatic logic [23:0] pixelOf(input int pos, input int pat);
    int h;
    int v;
    h = pos % H_TOT;
    v = pos / H_TOT;
    if (!isVisible(pos)) return 24'h0;
    case (pat)
      0: begin
        if (v < V_ACT / 3)          return 24'hFF0000;
        else if (v < 2 * V_ACT / 3) return 24'h00FF00;
        else                        return 24'h0000FF;
      end
      1:       return (v == V_ACT / 2) ? 24'hFF00FF : 24'hFFC0CB;
      default: return {8'((h / 4) % 256), 16'h0000};
    endcase
  endfunction

  // Reference model: mPos is the raster position the DUT counters hold after each edge,
  // the exp* values are what the registered outputs must show after that edge.
  initial begin
    mPos = 0; mPat = 0; mPend = 0; mCnt = 0;
    expRgb = '0; expAct = 0; expFs = 0; modelValid = 0;
    forever begin
      @(posedge clk);
      if (srst) begin
        mPos = 0; mPat = 0; mPend = 0; mCnt = 0;
        expRgb = '0; expAct = 0; expFs = 0;
        modelValid = 1;
      end else begin
        wrapNow = (mPos == FRAME - 1);
        advNow  = wrapNow && (mPend || nextReq);
`ifdef PATTERN_AUTO_CYCLE_EN
        if (wrapNow && !holdIn && mCnt == FPP - 1) advNow = 1;
        if (wrapNow) mCnt = advNow ? 0 : (holdIn ? mCnt : mCnt + 1);
`endif
        expRgb = pixelOf(mPos, mPat);
        expAct = isVisible(mPos);
        expFs  = (mPos == 0);
        mPend  = wrapNow ? 1'b0 : (mPend || nextReq);
        if (advNow) mPat = (mPat + 1) % 3;
        mPos = (mPos + 1) % FRAME;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (modelValid) begin
        checkCount++;
        if ({oRed, oGreen, oBlue} !== expRgb || oActive !== expAct ||
            oFrameStart !== expFs || oPatternId !== 2'(mPat)) begin
          $display("[TB] FAIL cycleCompare t=%0t pos=%0d: got rgb=%06h act=%b fs=%b pat=%0d, expected rgb=%06h act=%b fs=%b pat=%0d",
                   $time, mPos, {oRed, oGreen, oBlue}, oActive, oFrameStart, oPatternId,
                   expRgb, expAct, expFs, mPat);
        end else begin
          passCount++;
        end
      end
    end
  end

  task automatic applyStimulus(input bit req, input bit hld, input bit rst);
    #1;
    nextReq = req;
    holdIn  = hld;
    srst    = rst;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    else
      passCount++;
  endtask

  task automatic waitPos(input int p);
    int guard;
    guard = 0;
    while (mPos != p && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (mPos != p) checkOutput("waitPosTimeout", mPos, p);
  endtask

  task automatic pulseAt(input int p);
    waitPos(p);
    applyStimulus(1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0);
  endtask

  initial begin
    int n;
    int actCnt;
    bit holdVar;
    int expSeq[3];
    expSeq = '{1, 2, 0};
    srst = 1'b1; nextReq = 1'b0; holdIn = 1'b0;

    @(negedge clk);
    checkOutput("resetRgb", int'({oRed, oGreen, oBlue}), 0);
    checkOutput("resetActive", oActive, 0);
    checkOutput("resetFrameStart", oFrameStart, 0);
    repeat (2) @(negedge clk);
    applyStimulus(0, 0, 0);

    @(negedge clk);
    checkOutput("firstFrameStart", oFrameStart, 1);
    checkOutput("resetPattern", oPatternId, 0);
    checkOutput("pixel00Red", oRed, 8'hFF);
    n = 0;
    actCnt = oActive;
    while (n < 2 * FRAME) begin
      @(negedge clk);
      n++;
      if (oFrameStart) break;
      actCnt += oActive;
    end
    checkOutput("framePeriod", n, 320);
    checkOutput("activePerFrame", actCnt, 192);

    pulseAt(50);
    waitPos(86);
    checkOutput("barsGreenRowRed", oRed, 8'h00);
    checkOutput("barsGreenRowGreen", oGreen, 8'hFF);
    pulseAt(100);
    waitPos(166);
    checkOutput("barsBlueRowBlue", oBlue, 8'hFF);
    pulseAt(200);
    waitPos(FRAME - 1);
    checkOutput("patternBeforeWrap", oPatternId, 0);
    @(negedge clk);
    checkOutput("singleAdvance", oPatternId, 1);

    waitPos(46);
    checkOutput("linePinkRgb", int'({oRed, oGreen, oBlue}), 24'hFFC0CB);
    waitPos(126);
    checkOutput("lineMagentaRgb", int'({oRed, oGreen, oBlue}), 24'hFF00FF);
    waitPos(FRAME - 1);
    applyStimulus(1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0);
    checkOutput("wrapCycleRequest", oPatternId, 2);

    waitPos(61);
    checkOutput("gradRgb", int'({oRed, oGreen, oBlue}), 24'h050000);
    checkOutput("gradActive", oActive, 1);
    waitPos(76);
    checkOutput("blankRgb", int'({oRed, oGreen, oBlue}), 0);
    checkOutput("blankActive", oActive, 0);

    waitPos(100);
    applyStimulus(1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 1);
    @(negedge clk);
    checkOutput("midResetRed", oRed, 0);
    checkOutput("midResetPattern", oPatternId, 0);
    applyStimulus(0, 0, 0);
    waitPos(FRAME - 1);
    @(negedge clk);
    checkOutput("pendingDiscarded", oPatternId, 0);

    for (int k = 0; k < 3; k++) begin
      pulseAt(10);
      waitPos(FRAME - 1);
      @(negedge clk);
      checkOutput("manualCycle", oPatternId, expSeq[k]);
    end

    holdVar = 0;
    for (int c = 0; c < 60 * FRAME; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) holdVar = ~holdVar;
      applyStimulus($urandom_range(0, 199) == 0, holdVar, $urandom_range(0, 4999) == 0);
    end
    @(negedge clk);
    applyStimulus(0, 0, 0);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
